// File: rtl/iter_divider.sv
// Multi-cycle restoring radix-2 integer divider shared by both issue slots.
// Works on operand magnitudes, then applies the quotient/remainder signs in a fix-up cycle.
module iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic                  exception,
  output logic [DATA_WIDTH-1:0] s,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  complete,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FIX  = 3'd2,
    ST_DONE = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  function automatic logic [W-1:0] twos_neg(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          armed_r;
  logic          q_neg_r, r_neg_r, y_zero_r;
  logic [W-1:0]  x_raw_r, dvd_r, dvs_r, rem_r;
  logic [W-1:0]  s_r, r_r;

  logic          accept_s, x_neg_s, y_neg_s, ge_s;
  logic [W:0]    rem_shift_s, diff_s;
  logic [W-1:0]  rem_next_s, s_fix_s, r_fix_s;

  assign accept_s = (state_r == ST_IDLE) && div && armed_r && !exception;
  assign x_neg_s  = div_signed & x[W-1];
  assign y_neg_s  = div_signed & y[W-1];

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    state_s = state_r;
    if (exception) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = (div && armed_r) ? ST_CALC : ST_IDLE;
        ST_CALC: state_s = (cnt_r == LAST_STEP) ? ST_FIX : ST_CALC;
        ST_FIX:  state_s = ST_DONE;
        ST_DONE: state_s = div ? ST_WAIT : ST_IDLE;
        ST_WAIT: state_s = div ? ST_WAIT : ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // One restoring step plus the sign/divide-by-zero fix-up of the result.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[W-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    // The borrow bit says whether the divisor fit into the shifted remainder.
    ge_s        = ~diff_s[W];
    rem_next_s  = ge_s ? diff_s[W-1:0] : rem_shift_s[W-1:0];
    if (y_zero_r) begin
      s_fix_s = {W{1'b1}};
      r_fix_s = x_raw_r;
    end else begin
      s_fix_s = q_neg_r ? twos_neg(dvd_r) : dvd_r;
      r_fix_s = r_neg_r ? twos_neg(rem_r) : rem_r;
    end
  end

  // State and request-arming register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      armed_r <= 1'b1;
    end else begin
      state_r <= state_s;
      if (exception || !div) begin
        armed_r <= 1'b1;
      end else if (state_s == ST_DONE) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CW{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      y_zero_r <= 1'b0;
      x_raw_r  <= {W{1'b0}};
      dvd_r    <= {W{1'b0}};
      dvs_r    <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      s_r      <= {W{1'b0}};
      r_r      <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            q_neg_r  <= x_neg_s ^ y_neg_s;
            r_neg_r  <= x_neg_s;
            y_zero_r <= (y == {W{1'b0}});
            x_raw_r  <= x;
            dvd_r    <= x_neg_s ? twos_neg(x) : x;
            dvs_r    <= y_neg_s ? twos_neg(y) : y;
            rem_r    <= {W{1'b0}};
          end
        end
        ST_CALC: begin
          // Dividend shifts out at the top while quotient bits enter at the bottom.
          rem_r <= rem_next_s;
          dvd_r <= {dvd_r[W-2:0], ge_s};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        ST_FIX: begin
          if (!exception) begin
            s_r <= s_fix_s;
            r_r <= r_fix_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s        = s_r;
  assign r        = r_r;
  assign complete = (state_r == ST_DONE) && !exception;
  assign busy     = (state_r == ST_CALC) || (state_r == ST_FIX);

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: expected results are queued at request time
// and compared when complete is observed.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset, div, div_signed, exception;
  logic [31:0] x, y, s, r;
  logic        complete, busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_sr;

  iter_divider #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div(div), .div_signed(div_signed),
    .x(x), .y(y), .exception(exception),
    .s(s), .r(r), .complete(complete), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Raise div with operands, wait (bounded) for complete, compare against the scoreboard.
  task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] es,
                       input logic [31:0] er, input bit hold);
    int lat;
    int bcnt;
    bit seen;
    logic [63:0] exp_v;
    sb_q.push_back({es, er});
    div_signed = sg; x = a; y = b; div = 1'b1;
    lat = 0; bcnt = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        x = $urandom; y = $urandom; div_signed = ~sg;
      end
      if (busy) bcnt++;
      if (complete) seen = 1'b1;
    end
    chk({tag, "_complete_seen"}, 64'(seen), 64'd1);
    exp_v = sb_q.pop_front();
    if (seen) begin
      chk({tag, "_sr"}, {s, r}, exp_v);
      chk({tag, "_latency"}, 64'(lat), 64'd34);
      chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
      last_sr = exp_v;
    end
    if (!hold) div = 1'b0;
    @(negedge clk);
    chk({tag, "_single_pulse"}, 64'(complete), 64'd0);
  endtask

  initial begin
    int ncmp;
    int nbusy;
    reset = 1'b1; div = 1'b0; div_signed = 1'b0; exception = 1'b0;
    x = 32'd0; y = 32'd0; last_sr = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset_sr", {s, r}, 64'd0);
    chk("reset_complete", 64'(complete), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("u7_2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    do_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    do_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    do_op("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    do_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    do_op("u_div0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b0);
    do_op("s_div0", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b0);

    // Flush ten cycles after accept: no completion, results untouched.
    div_signed = 1'b0; x = 32'd100; y = 32'd7; div = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    exception = 1'b1; div = 1'b0;
    @(negedge clk);
    exception = 1'b0;
    ncmp = 0;
    repeat (40) begin
      @(negedge clk);
      if (complete) ncmp++;
    end
    chk("flush_no_complete", 64'(ncmp), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_sr_kept", {s, r}, last_sr);
    do_op("after_flush_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Request and flush together in IDLE must not start a divide.
    div = 1'b1; exception = 1'b1; x = 32'd5; y = 32'd1;
    @(negedge clk);
    div = 1'b0; exception = 1'b0;
    chk("div_and_flush_no_accept", 64'(busy), 64'd0);
    @(negedge clk);

    // Held request after completion must not retrigger.
    do_op("hold_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    x = 32'd9; y = 32'd4;
    ncmp = 0; nbusy = 0;
    repeat (4) begin
      @(negedge clk);
      if (complete) ncmp++;
      if (busy) nbusy++;
    end
    chk("hold_no_recomplete", 64'(ncmp), 64'd0);
    chk("hold_no_restart", 64'(nbusy), 64'd0);
    div = 1'b0;
    @(negedge clk);
    do_op("retrigger_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Reset in the middle of CALC.
    div_signed = 1'b0; x = 32'd100; y = 32'd7; div = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1; div = 1'b0;
    @(negedge clk);
    chk("midreset_sr", {s, r}, 64'd0);
    chk("midreset_complete", 64'(complete), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    do_op("after_reset_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
